// File: rtl/incr_arbiter.sv
// Round-robin arbiter that grants one requester at a time access to a shared
// counter increment, waits for the datapath echo, and reports completion or timeout.
module incr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_in,
    input  logic               ack_in,
    output logic               incr_out,
    output logic [NUM_REQ-1:0] grant_out,
    output logic [NUM_REQ-1:0] done_out,
    output logic               err_out,
    output logic [7:0]         grant_count_out,
    output logic [1:0]         dbg_state_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Handshake: incr_out is a one-cycle strobe in ISSUE; ack_in is the
    // datapath's registered echo and is only honoured while in WAIT_ACK.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [3:0]         timer_q, timer_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               err_q, err_d;
    logic [7:0]         count_q, count_d;

    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   win_next;

    // Lowest set bit at or above ptr wins; failing that, the lowest set bit below ptr.
    always_comb begin
        win_idx = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_in[j] && (j < int'(ptr_q))) begin
                win_idx = PTR_W'(j);
            end
        end
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_in[j] && (j >= int'(ptr_q))) begin
                win_idx = PTR_W'(j);
            end
        end
    end

    assign win_next = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        timer_d = timer_q;
        grant_d = grant_q;
        done_d  = '0;
        err_d   = err_q;
        count_d = count_q;

        unique case (state_q)
            IDLE: begin
                if (|req_in) begin
                    grant_d = NUM_REQ'(1) << win_idx;
                    ptr_d   = win_next;
                    state_d = ISSUE;
                end else begin
                    grant_d = '0;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (ack_in) begin
                    done_d  = grant_q;
                    count_d = count_q + 8'd1;
                    grant_d = '0;
                    timer_d = '0;
                    state_d = IDLE;
                end else if (timer_q == 4'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    grant_d = '0;
                    timer_d = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 4'd1;
                end
            end
            default: begin
                grant_d = '0;
                timer_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            timer_q <= '0;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            timer_q <= timer_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    assign incr_out        = (state_q == ISSUE);
    assign grant_out       = grant_q;
    assign done_out        = done_q;
    assign err_out         = err_q;
    assign grant_count_out = count_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_incr_arbiter.sv
// Directed bench for incr_arbiter: reset, single grant, round-robin order,
// ack timeout, reset mid-transaction, count wrap, dropped request and spurious ack.
module tb_incr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req_in;
    logic       ack_in;
    logic       incr_out;
    logic [3:0] grant_out;
    logic [3:0] done_out;
    logic       err_out;
    logic [7:0] grant_count_out;
    logic [1:0] dbg_state_o;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic auto_ack  = 1'b0;
    logic man_ack   = 1'b0;
    logic last_incr = 1'b0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    incr_arbiter #(.NUM_REQ(4), .TIMEOUT(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_in          (req_in),
        .ack_in          (ack_in),
        .incr_out        (incr_out),
        .grant_out       (grant_out),
        .done_out        (done_out),
        .err_out         (err_out),
        .grant_count_out (grant_count_out),
        .dbg_state_o     (dbg_state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; ack_in is either the echo of last cycle's incr_out or a forced value.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        ack_in    = auto_ack ? last_incr : man_ack;
        last_incr = incr_out;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_incr(input string tag);
        int k;
        k = 0;
        while (incr_out !== 1'b1 && k < 10) begin
            tick();
            k++;
        end
        check(tag, {31'd0, incr_out}, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int cnt [4];
        int last_cyc;
        rst     = 1'b1;
        req_in  = 4'b0000;
        ack_in  = 1'b0;

        // Reset state
        do_reset();
        check("rst_state", dbg_state_o, S_IDLE);
        check("rst_grant", grant_out, 4'b0000);
        check("rst_incr",  incr_out, 1'b0);
        check("rst_done",  done_out, 4'b0000);
        check("rst_err",   err_out, 1'b0);
        check("rst_count", grant_count_out, 8'd0);

        // Single request with echoed ack
        auto_ack = 1'b1;
        req_in   = 4'b0010;
        tick();
        check("single_issue_incr",  incr_out, 1'b1);
        check("single_issue_grant", grant_out, 4'b0010);
        tick();
        check("single_wait_incr",   incr_out, 1'b0);
        check("single_wait_state",  dbg_state_o, S_WAIT);
        tick();
        check("single_done",  done_out, 4'b0010);
        check("single_count", grant_count_out, 8'd1);
        check("single_grant_idle", grant_out, 4'b0000);
        req_in = 4'b0000;
        tick();
        check("single_done_clear", done_out, 4'b0000);
        check("single_idle_incr",  incr_out, 1'b0);

        // Round-robin with all requesting, back-to-back
        do_reset();
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        req_in   = 4'b1111;
        last_cyc = 0;
        for (int g = 0; g < 12; g++) begin
            wait_incr("rr_incr_seen");
            check($sformatf("rr_grant_%0d", g), grant_out, 4'b0001 << (g % 4));
            if (g > 0) check($sformatf("rr_spacing_%0d", g), cyc - last_cyc, 3);
            last_cyc = cyc;
            for (int i = 0; i < 4; i++) if (grant_out[i]) cnt[i]++;
            tick();
            if (g == 11) req_in = 4'b0000;
        end
        tick();
        check("rr_count", grant_count_out, 8'd12);
        for (int i = 0; i < 4; i++) check($sformatf("rr_share_%0d", i), cnt[i], 3);
        tick();

        // Ack timeout, then a further request still completes
        do_reset();
        auto_ack = 1'b0;
        man_ack  = 1'b0;
        req_in   = 4'b0001;
        tick();
        check("to_issue_grant", grant_out, 4'b0001);
        repeat (4) tick();
        check("to_wait_state", dbg_state_o, S_WAIT);
        check("to_wait_err",   err_out, 1'b0);
        tick();
        check("to_err",   err_out, 1'b1);
        check("to_state", dbg_state_o, S_IDLE);
        check("to_grant", grant_out, 4'b0000);
        check("to_done",  done_out, 4'b0000);
        check("to_count", grant_count_out, 8'd0);
        auto_ack = 1'b1;
        tick();
        check("to_retry_incr", incr_out, 1'b1);
        tick();
        req_in = 4'b0000;
        tick();
        check("to_retry_done",  done_out, 4'b0001);
        check("to_retry_count", grant_count_out, 8'd1);
        check("to_err_sticky",  err_out, 1'b1);

        // Reset during WAIT_ACK, then a late ack
        auto_ack = 1'b0;
        man_ack  = 1'b0;
        req_in   = 4'b0100;
        tick();
        tick();
        check("mr_in_wait", dbg_state_o, S_WAIT);
        rst    = 1'b1;
        req_in = 4'b0000;
        tick();
        rst     = 1'b0;
        man_ack = 1'b1;
        check("mr_state", dbg_state_o, S_IDLE);
        check("mr_grant", grant_out, 4'b0000);
        check("mr_err",   err_out, 1'b0);
        check("mr_count", grant_count_out, 8'd0);
        tick();
        man_ack = 1'b0;
        check("mr_late_done",  done_out, 4'b0000);
        check("mr_late_count", grant_count_out, 8'd0);
        check("mr_late_state", dbg_state_o, S_IDLE);

        // Count wrap after 256 completions
        do_reset();
        auto_ack = 1'b1;
        req_in   = 4'b0001;
        for (int n = 1; n <= 256; n++) begin
            wait_incr("wrap_incr_seen");
            if (n == 256) check("wrap_before_last", grant_count_out, 8'd255);
            tick();
            if (n == 256) req_in = 4'b0000;
            tick();
        end
        check("wrap_count", grant_count_out, 8'd0);
        check("wrap_done",  done_out, 4'b0001);
        check("wrap_err",   err_out, 1'b0);
        tick();

        // Requester drops req_in after being granted
        req_in = 4'b1000;
        tick();
        check("drop_grant", grant_out, 4'b1000);
        req_in = 4'b0000;
        tick();
        tick();
        check("drop_done",  done_out, 4'b1000);
        check("drop_count", grant_count_out, 8'd1);
        tick();

        // Spurious ack while idle
        auto_ack = 1'b0;
        man_ack  = 1'b1;
        tick();
        tick();
        man_ack = 1'b0;
        tick();
        check("sp_state", dbg_state_o, S_IDLE);
        check("sp_incr",  incr_out, 1'b0);
        check("sp_grant", grant_out, 4'b0000);
        check("sp_done",  done_out, 4'b0000);
        check("sp_count", grant_count_out, 8'd1);
        check("sp_err",   err_out, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/incr_arbiter.md
INCR_ARBITER -- requirements
Module: incr_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_REQ, default 4, giving the number of requesters (legal range 2..8).
REQ-002 The module SHALL have parameter TIMEOUT, default 4, giving the maximum WAIT_ACK cycles before abort (legal range 2..15).
REQ-003 Port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 Port rst  input  1  synchronous, active-high reset; sampled on posedge clk.
REQ-005 Port req_in  input  NUM_REQ  level request per requester; held high until that requester's done_out pulse.
REQ-006 Port ack_in  input  1  echo from counter datapath (its one-cycle-delayed copy of incr_out).
REQ-007 Port incr_out  output  1  single-cycle increment strobe to the shared counter.
REQ-008 Port grant_out  output  NUM_REQ  one-hot owner of the current transaction; all-zero when idle.
REQ-009 Port done_out  output  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-010 Port err_out  output  1  sticky timeout flag.
REQ-011 Port grant_count_out  output  8  completed-transaction count.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, ISSUE, WAIT_ACK.
REQ-013 IDLE with req_in != 0: winner = first set bit searching upward from ptr, wrapping at NUM_REQ-1 to 0; next cycle is ISSUE with grant_out = onehot(winner).
REQ-014 IDLE with req_in == 0: remain in IDLE; grant_out = 0, incr_out = 0.
REQ-015 incr_out SHALL be 1 in every ISSUE cycle and 0 otherwise; ISSUE lasts exactly one cycle, then WAIT_ACK.
REQ-016 On entry to WAIT_ACK, timer SHALL be 0; timer increments each WAIT_ACK cycle without ack_in.
REQ-017 WAIT_ACK with ack_in = 1: next cycle done_out = grant_out for one cycle, grant_count_out increments, state -> IDLE, grant_out -> 0.
REQ-018 WAIT_ACK with ack_in = 0 and timer == TIMEOUT-1: next cycle err_out = 1, state -> IDLE, grant_out -> 0, no done_out, count unchanged.
REQ-019 ack_in in IDLE or ISSUE SHALL be ignored (no state, count, or err change).
REQ-020 ptr SHALL update to (winner+1) mod NUM_REQ at the IDLE->ISSUE transition.
REQ-021 A requester dropping req_in after grant SHALL NOT abort the transaction; it completes or times out normally.
REQ-022 Minimum spacing of incr_out pulses SHALL be 3 cycles (IDLE, ISSUE, WAIT_ACK with immediate ack).
REQ-023 The IDLE cycle in which done_out is high SHALL also arbitrate, so back-to-back requests proceed without extra idle cycles.
REQ-024 grant_count_out SHALL wrap 255 -> 0 with no flag.
REQ-025 err_out, once set, SHALL remain 1 until reset; arbitration continues normally while it is set.
REQ-026 At most one bit of grant_out and of done_out SHALL be set in any cycle.

Reset
REQ-027 rst = 1 SHALL force, on the next edge: state IDLE, ptr 0, timer 0, incr_out 0, grant_out 0, done_out 0, err_out 0, grant_count_out 0.
REQ-028 rst asserted mid-transaction (ISSUE or WAIT_ACK) SHALL abandon it with no done_out and no count change; a late ack_in after reset is ignored per REQ-019.
REQ-029 rst SHALL take priority over every other input in the same cycle.

Verification
REQ-030 Single request: req_in=4'b0010, ack_in = incr_out delayed 1 cycle -> incr_out high once, grant_out=0010, done_out=0010 two cycles later, grant_count_out=1.
REQ-031 Round-robin fairness: req_in=4'b1111 held for 12 completed grants -> grant order 0,1,2,3,0,1,2,3,... and each requester gets 3 grants.
REQ-032 Ack timeout: req_in=4'b0001, ack_in held 0 -> after 4 WAIT_ACK cycles err_out=1 (sticky), no done_out, count stays 0; the next request still completes.
REQ-033 Reset mid-transaction: rst pulsed during WAIT_ACK -> all outputs 0 next cycle; a subsequent ack_in pulse causes no done_out or count change.
REQ-034 Count wrap: 256 completed grants -> grant_count_out returns to 0, with 255 observed immediately before the last completion.
REQ-035 Spurious ack: ack_in pulsed during IDLE with req_in=0 -> no output changes.
